// File: rtl/rx_deframer.sv
// Receive-side frame parser: hunts for the sync word, captures the generator seed, buffers payload words.
// Optional statistics counters are built when RX_DEFRAMER_STATS_EN is defined; otherwise they read as 0.
//
//   state   | meaning
//   HUNT    | sliding two-byte search for SYNC_WORD
//   STATE   | shifting in the 4 seed bytes
//   PAYLOAD | assembling byte pairs into words and pushing them to the FIFO

module rx_deframer #(
   parameter int          PAYLOAD_WORDS = 32,
   parameter int          FIFO_DEPTH    = 4,
   parameter int          GAP_TIMEOUT   = 4096,
   parameter logic [15:0] SYNC_WORD     = 16'hCAFE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_enable,
   input  logic [7:0]  rx_data,
   input  logic        rx_done,
   output logic [15:0] word_out,
   output logic        word_valid,
   input  logic        word_ready,
   output logic        next_key_en,
   output logic        sync_en,
   output logic [31:0] sync_state_out,
   output logic        in_frame,
   output logic        frame_err,
   output logic        ovf_err,
   output logic [15:0] frame_count,
   output logic [15:0] err_count
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int WCW = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
   localparam int TW  = $clog2(GAP_TIMEOUT);

   typedef enum logic [1:0] {HUNT, STATE, PAYLOAD} state_t;

   state_t           state_q, state_d;
   logic [7:0]       prev_q;
   logic [1:0]       byte_cnt_q;
   logic [WCW-1:0]   word_cnt_q;
   logic [TW-1:0]    gap_q;
   logic [23:0]      seed_sr_q;
   logic [7:0]       hi_q;

   logic [15:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    count_q;

   logic byte_en, gap_tc, timeout, seed_done, frame_done, push_req;
   logic pop, full, push_ok, drop, flush;

   assign byte_en = rx_enable && rx_done;
   assign gap_tc  = (gap_q == '0);

   always_ff @(posedge clk) begin
      if (rst) state_q <= HUNT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      timeout    = 1'b0;
      seed_done  = 1'b0;
      frame_done = 1'b0;
      push_req   = 1'b0;
      if (!rx_enable) begin
         state_d = HUNT;
      end else begin
         case (state_q)
            HUNT: begin
               if (rx_done && ({prev_q, rx_data} == SYNC_WORD)) state_d = STATE;
            end
            STATE: begin
               if (rx_done) begin
                  if (byte_cnt_q == 2'd3) begin
                     seed_done = 1'b1;
                     state_d   = PAYLOAD;
                  end
               end else if (gap_tc) begin
                  timeout = 1'b1;
                  state_d = HUNT;
               end
            end
            PAYLOAD: begin
               if (rx_done) begin
                  if (byte_cnt_q[0]) begin
                     push_req = 1'b1;
                     if (word_cnt_q == WCW'(PAYLOAD_WORDS - 1)) begin
                        frame_done = 1'b1;
                        state_d    = HUNT;
                     end
                  end
               end else if (gap_tc) begin
                  timeout = 1'b1;
                  state_d = HUNT;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   assign in_frame = (state_q != HUNT);

   // Byte/word bookkeeping and the inter-byte gap down-counter
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q     <= '0;
         byte_cnt_q <= '0;
         word_cnt_q <= '0;
         gap_q      <= TW'(GAP_TIMEOUT - 1);
         seed_sr_q  <= '0;
         hi_q       <= '0;
      end else begin
         if (!rx_enable || frame_done)            prev_q <= '0;
         else if (state_q == HUNT && rx_done)     prev_q <= rx_data;

         if (state_q == HUNT)                     byte_cnt_q <= '0;
         else if (byte_en)                        byte_cnt_q <= byte_cnt_q + 2'd1;

         if (state_q != PAYLOAD)                  word_cnt_q <= '0;
         else if (push_req)                       word_cnt_q <= word_cnt_q + WCW'(1);

         if (byte_en || state_q == HUNT)          gap_q <= TW'(GAP_TIMEOUT - 1);
         else if (!gap_tc)                        gap_q <= gap_q - TW'(1);

         if (state_q == STATE && byte_en)         seed_sr_q <= {seed_sr_q[15:0], rx_data};
         if (state_q == PAYLOAD && byte_en && !byte_cnt_q[0]) hi_q <= rx_data;
      end
   end

   assign word_valid = (count_q != '0);
   assign full       = (count_q == CW'(FIFO_DEPTH));
   assign pop        = word_valid && word_ready;
   assign push_ok    = push_req && (!full || pop);
   assign drop       = push_req && !push_ok;
   assign flush      = !rx_enable || seed_done;
   assign word_out   = word_valid ? mem[rd_q] : '0;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_q] <= {hi_q, rx_data};
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + AW'(1);
         if (pop)     rd_q <= rd_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_en        <= 1'b0;
         sync_state_out <= '0;
         next_key_en    <= 1'b0;
         frame_err      <= 1'b0;
         ovf_err        <= 1'b0;
      end else begin
         sync_en     <= seed_done;
         next_key_en <= pop && rx_enable;
         frame_err   <= timeout;
         ovf_err     <= drop;
         if (seed_done) sync_state_out <= {seed_sr_q, rx_data};
      end
   end

`ifdef RX_DEFRAMER_STATS_EN
   logic [15:0] frame_count_q, err_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_count_q <= '0;
         err_count_q   <= '0;
      end else begin
         if (frame_done && frame_count_q != 16'hFFFF) frame_count_q <= frame_count_q + 16'd1;
         if ((timeout || drop) && err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
      end
   end

   assign frame_count = frame_count_q;
   assign err_count   = err_count_q;
`else
   assign frame_count = '0;
   assign err_count   = '0;
`endif

endmodule

// File: tb/tb_rx_deframer.sv
// Directed bench for rx_deframer: clean frame, misaligned hunt, gap timeout, backpressure,
// full-FIFO push with pop, rx_enable drop and mid-seed reset.

module tb_rx_deframer;

`ifdef RX_DEFRAMER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_enable = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_done = 1'b0;
   logic [15:0] word_out;
   logic        word_valid;
   logic        word_ready = 1'b0;
   logic        next_key_en;
   logic        sync_en;
   logic [31:0] sync_state_out;
   logic        in_frame;
   logic        frame_err;
   logic        ovf_err;
   logic [15:0] frame_count;
   logic [15:0] err_count;

   int n_cmp = 0;
   int n_bad = 0;

   int n_sync = 0, n_nke = 0, n_ferr = 0, n_ovf = 0, pop_n = 0;
   logic [15:0] pop_log [0:255];

   rx_deframer #(
      .PAYLOAD_WORDS(6), .FIFO_DEPTH(4), .GAP_TIMEOUT(16), .SYNC_WORD(16'hCAFE)
   ) dut (
      .clk(clk), .rst(rst), .rx_enable(rx_enable), .rx_data(rx_data), .rx_done(rx_done),
      .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
      .next_key_en(next_key_en), .sync_en(sync_en), .sync_state_out(sync_state_out),
      .in_frame(in_frame), .frame_err(frame_err), .ovf_err(ovf_err),
      .frame_count(frame_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Inputs change only on negedges, so sampling here sees stable pre-edge values
   always @(posedge clk) begin
      if (sync_en)     n_sync++;
      if (next_key_en) n_nke++;
      if (frame_err)   n_ferr++;
      if (ovf_err)     n_ovf++;
      if (word_valid && word_ready && pop_n < 256) begin
         pop_log[pop_n] = word_out;
         pop_n++;
      end
   end

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic send_header(input logic [31:0] seed);
      send_byte(8'hCA);
      send_byte(8'hFE);
      send_byte(seed[31:24]);
      send_byte(seed[23:16]);
      send_byte(seed[15:8]);
      send_byte(seed[7:0]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      word_ready = 1'b0;
      rx_enable = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycles(1);
   endtask

   task automatic test_reset();
      logic [15:0] exp16;
      do_reset();
      rst = 1'b1;
      cycles(1);
      exp16 = '0;
      n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL reset_word_valid: got %b expected 0", word_valid); end
      n_cmp++; if (word_out !== exp16) begin n_bad++; $display("FAIL reset_word_out: got %h expected %h", word_out, exp16); end
      n_cmp++; if (sync_state_out !== 32'h0) begin n_bad++; $display("FAIL reset_sync_state: got %h expected 0", sync_state_out); end
      n_cmp++; if (in_frame !== 1'b0) begin n_bad++; $display("FAIL reset_in_frame: got %b expected 0", in_frame); end
      n_cmp++; if ({sync_en, next_key_en, frame_err, ovf_err} !== 4'b0000) begin n_bad++; $display("FAIL reset_pulses: got %b expected 0000", {sync_en, next_key_en, frame_err, ovf_err}); end
      n_cmp++; if (frame_count !== exp16 || err_count !== exp16) begin n_bad++; $display("FAIL reset_counters: got %h/%h expected 0/0", frame_count, err_count); end
      rst = 1'b0;
      cycles(1);
   endtask

   task automatic test_clean_frame();
      logic [15:0] words [6];
      int s0, nk0, f0, p0;
      words = '{16'h0001, 16'hABCD, 16'h1357, 16'h2468, 16'hCAFE, 16'h0F0F};
      do_reset();
      word_ready = 1'b1;
      s0 = n_sync; nk0 = n_nke; f0 = n_ferr; p0 = pop_n;
      send_header(32'h12345678);
      n_cmp++; if (sync_en !== 1'b1) begin n_bad++; $display("FAIL clean_sync_en: got %b expected 1", sync_en); end
      n_cmp++; if (sync_state_out !== 32'h12345678) begin n_bad++; $display("FAIL clean_seed: got %h expected 12345678", sync_state_out); end
      n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL clean_fifo_flushed: got %b expected 0", word_valid); end
      send_word(words[0]);
      n_cmp++; if (word_valid !== 1'b1 || word_out !== 16'h0001) begin n_bad++; $display("FAIL clean_first_word: got %b/%h expected 1/0001", word_valid, word_out); end
      for (int i = 1; i < 6; i++) send_word(words[i]);
      n_cmp++; if (in_frame !== 1'b0) begin n_bad++; $display("FAIL clean_in_frame_end: got %b expected 0", in_frame); end
      cycles(4);
      n_cmp++; if (pop_n - p0 !== 6) begin n_bad++; $display("FAIL clean_pop_count: got %0d expected 6", pop_n - p0); end
      for (int i = 0; i < 6; i++) begin
         n_cmp++; if (pop_log[p0 + i] !== words[i]) begin n_bad++; $display("FAIL clean_word%0d: got %h expected %h", i, pop_log[p0 + i], words[i]); end
      end
      n_cmp++; if (n_nke - nk0 !== 6) begin n_bad++; $display("FAIL clean_next_key: got %0d expected 6", n_nke - nk0); end
      n_cmp++; if (n_sync - s0 !== 1) begin n_bad++; $display("FAIL clean_sync_pulses: got %0d expected 1", n_sync - s0); end
      n_cmp++; if (n_ferr !== f0) begin n_bad++; $display("FAIL clean_frame_err: got %0d expected 0", n_ferr - f0); end
      n_cmp++; if (frame_count !== (STATS ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL clean_frame_count: got %0d expected %0d", frame_count, STATS ? 1 : 0); end
      word_ready = 1'b0;
   endtask

   task automatic test_misaligned_hunt();
      int s0, f0;
      do_reset();
      s0 = n_sync; f0 = n_ferr;
      send_byte(8'h00);
      send_byte(8'hCA);
      send_byte(8'hCA);
      n_cmp++; if (in_frame !== 1'b0) begin n_bad++; $display("FAIL hunt_no_early_lock: got %b expected 0", in_frame); end
      send_byte(8'hFE);
      n_cmp++; if (in_frame !== 1'b1) begin n_bad++; $display("FAIL hunt_lock: got %b expected 1", in_frame); end
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
      n_cmp++; if (sync_en !== 1'b1 || sync_state_out !== 32'h00000001) begin n_bad++; $display("FAIL hunt_seed: got %b/%h expected 1/00000001", sync_en, sync_state_out); end
      cycles(3);
      n_cmp++; if (n_sync - s0 !== 1) begin n_bad++; $display("FAIL hunt_sync_pulses: got %0d expected 1", n_sync - s0); end
      n_cmp++; if (n_ferr !== f0) begin n_bad++; $display("FAIL hunt_frame_err: got %0d expected 0", n_ferr - f0); end
   endtask

   task automatic test_gap_timeout();
      int k, f0;
      do_reset();
      f0 = n_ferr;
      send_header(32'hDEADBEEF);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      k = 0;
      while (frame_err !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      n_cmp++; if (k !== 16) begin n_bad++; $display("FAIL gap_latency: got %0d cycles expected 16", k); end
      n_cmp++; if (in_frame !== 1'b0) begin n_bad++; $display("FAIL gap_in_frame: got %b expected 0", in_frame); end
      n_cmp++; if (word_valid !== 1'b1 || word_out !== 16'h1122) begin n_bad++; $display("FAIL gap_word_kept: got %b/%h expected 1/1122", word_valid, word_out); end
      cycles(2);
      n_cmp++; if (n_ferr - f0 !== 1) begin n_bad++; $display("FAIL gap_pulses: got %0d expected 1", n_ferr - f0); end
      n_cmp++; if (err_count !== (STATS ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL gap_err_count: got %0d expected %0d", err_count, STATS ? 1 : 0); end
   endtask

   task automatic test_backpressure();
      int o0, p0, nk0;
      do_reset();
      o0 = n_ovf; p0 = pop_n; nk0 = n_nke;
      send_header(32'h0BADF00D);
      for (int i = 1; i <= 6; i++) send_word(16'h1111 * i[15:0]);
      cycles(2);
      n_cmp++; if (n_ovf - o0 !== 2) begin n_bad++; $display("FAIL bp_ovf_pulses: got %0d expected 2", n_ovf - o0); end
      n_cmp++; if (err_count !== (STATS ? 16'd2 : 16'd0)) begin n_bad++; $display("FAIL bp_err_count: got %0d expected %0d", err_count, STATS ? 2 : 0); end
      n_cmp++; if (word_valid !== 1'b1 || word_out !== 16'h1111) begin n_bad++; $display("FAIL bp_head: got %b/%h expected 1/1111", word_valid, word_out); end
      word_ready = 1'b1;
      cycles(8);
      word_ready = 1'b0;
      cycles(2);
      n_cmp++; if (pop_n - p0 !== 4) begin n_bad++; $display("FAIL bp_pop_count: got %0d expected 4", pop_n - p0); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (pop_log[p0 + i] !== 16'h1111 * (i[15:0] + 16'd1)) begin n_bad++; $display("FAIL bp_word%0d: got %h expected %h", i, pop_log[p0 + i], 16'h1111 * (i[15:0] + 16'd1)); end
      end
      n_cmp++; if (n_nke - nk0 !== 4) begin n_bad++; $display("FAIL bp_next_key: got %0d expected 4", n_nke - nk0); end
      n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b expected 0", word_valid); end
   endtask

   task automatic test_full_with_pop();
      int o0, p0;
      logic [15:0] exp_w [5];
      exp_w = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
      do_reset();
      o0 = n_ovf; p0 = pop_n;
      send_header(32'h01020304);
      for (int i = 0; i < 4; i++) send_word(exp_w[i]);
      send_byte(8'hA0);
      rx_data = 8'h05;
      rx_done = 1'b1;
      word_ready = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      word_ready = 1'b0;
      n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL full_pop_no_ovf: got %b expected 0", ovf_err); end
      n_cmp++; if (word_out !== 16'hA002) begin n_bad++; $display("FAIL full_pop_head: got %h expected A002", word_out); end
      send_word(16'hA006);
      n_cmp++; if (ovf_err !== 1'b1) begin n_bad++; $display("FAIL full_still_full: got %b expected 1", ovf_err); end
      word_ready = 1'b1;
      cycles(8);
      word_ready = 1'b0;
      cycles(2);
      n_cmp++; if (pop_n - p0 !== 5) begin n_bad++; $display("FAIL full_pop_count: got %0d expected 5", pop_n - p0); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (pop_log[p0 + i] !== exp_w[i]) begin n_bad++; $display("FAIL full_word%0d: got %h expected %h", i, pop_log[p0 + i], exp_w[i]); end
      end
      n_cmp++; if (n_ovf - o0 !== 1) begin n_bad++; $display("FAIL full_ovf_pulses: got %0d expected 1", n_ovf - o0); end
   endtask

   task automatic test_enable_drop_and_reset();
      int f0, s0, nk0;
      do_reset();
      f0 = n_ferr;
      send_header(32'hAABBCCDD);
      send_word(16'h0102);
      send_word(16'h0304);
      send_byte(8'h05);
      n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("FAIL drop_pre_valid: got %b expected 1", word_valid); end
      rx_enable = 1'b0;
      @(negedge clk);
      n_cmp++; if (word_valid !== 1'b0 || in_frame !== 1'b0) begin n_bad++; $display("FAIL drop_flush: got valid %b in_frame %b expected 0 0", word_valid, in_frame); end
      send_byte(8'hCA);
      send_byte(8'hFE);
      n_cmp++; if (in_frame !== 1'b0) begin n_bad++; $display("FAIL drop_ignore_bytes: got %b expected 0", in_frame); end
      cycles(30);
      n_cmp++; if (n_ferr !== f0) begin n_bad++; $display("FAIL drop_no_frame_err: got %0d expected 0", n_ferr - f0); end
      rx_enable = 1'b1;
      word_ready = 1'b1;
      cycles(1);
      s0 = n_sync; nk0 = n_nke;
      send_byte(8'hCA); send_byte(8'hFE); send_byte(8'h11); send_byte(8'h22);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send_byte(8'h33); send_byte(8'h44);
      cycles(4);
      n_cmp++; if (n_sync !== s0) begin n_bad++; $display("FAIL rst_no_sync_en: got %0d expected 0", n_sync - s0); end
      n_cmp++; if (sync_state_out !== 32'h0) begin n_bad++; $display("FAIL rst_seed_cleared: got %h expected 0", sync_state_out); end
      n_cmp++; if (n_nke !== nk0) begin n_bad++; $display("FAIL rst_no_next_key: got %0d expected 0", n_nke - nk0); end
      n_cmp++; if (in_frame !== 1'b0) begin n_bad++; $display("FAIL rst_hunting: got %b expected 0", in_frame); end
      word_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean_frame();
      test_misaligned_hunt();
      test_gap_timeout();
      test_backpressure();
      test_full_with_pop();
      test_enable_drop_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
